// File: rtl/calc_pkg.sv
// Shared definitions for the ALU operation scheduler.
//   - Opcode constants understood by the ALU (one-hot encoded).
//   - Response error codes carried on rsp_err.
//   - Scheduler FSM state encoding.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0100;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Only exact one-hot opcodes are accepted; anything else is rejected.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Bundle of request, ALU and response signals of the ALU operation scheduler.
//   req0_* / req1_*  : two requesters (valid, operands a/b, opcode, ready pulse)
//   alu_*            : ALU launch strobes, operand/opcode bus, result and done flag
//   rsp_*            : response channel (valid/ready, id, result, error code)
// Modports:
//   slave  : the scheduler's view
//   master : the environment's view (requesters, ALU, response consumer)
interface alu_op_scheduler_if;

  logic       req0_valid;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [3:0] req0_op;
  logic       req0_ready;

  logic       req1_valid;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [3:0] req1_op;
  logic       req1_ready;

  logic       alu_sel;
  logic       alu_wr_enable;
  logic [3:0] alu_first_nr;
  logic [3:0] alu_second_nr;
  logic [3:0] alu_operation;
  logic [7:0] alu_result;
  logic       alu_done;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic [1:0] rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_sel, alu_wr_enable, alu_first_nr, alu_second_nr, alu_operation,
    input  alu_result, alu_done,
    output rsp_valid, rsp_id, rsp_result, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_sel, alu_wr_enable, alu_first_nr, alu_second_nr, alu_operation,
    output alu_result, alu_done,
    input  rsp_valid, rsp_id, rsp_result, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector, bit N = requester N
//   advance  : the current grant is being taken this cycle
//   gnt      : one-hot grant (zero when no request)
// On a tie the requester not granted last wins; after reset requester 1 counts as
// last granted, so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Schedules commands from two requesters onto a single shared ALU, one at a time.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : scheduler side of alu_op_scheduler_if
//              req0_*/req1_* accepted round-robin with a one-cycle ready pulse,
//              alu_* launch strobes and operand bus, rsp_* valid/ready response.
// Illegal opcodes and divide-by-zero are answered without launching the ALU; an ALU
// that never completes is answered with a timeout after TIMEOUT_CYCLES wait cycles.
module alu_op_scheduler
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input logic             clk,
  input logic             rst,
  alu_op_scheduler_if.slave bus
);

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;
  logic       id_q, id_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic [1:0] rsp_err_q, rsp_err_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       take;
  logic [3:0] sel_a, sel_b, sel_op;

  assign req  = {bus.req1_valid, bus.req0_valid};
  assign take = (state_q == StIdle) && (gnt != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (take),
    .gnt     (gnt)
  );

  assign sel_a  = gnt[1] ? bus.req1_a  : bus.req0_a;
  assign sel_b  = gnt[1] ? bus.req1_b  : bus.req0_b;
  assign sel_op = gnt[1] ? bus.req1_op : bus.req0_op;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // The ALU bus registers double as the latched command: they are loaded only for
  // commands that will actually be launched, so the bus holds its last launched value.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (take) begin
          id_d = gnt[1];
          if (!is_legal_op(sel_op)) begin
            state_d      = StResp;
            rsp_id_d     = gnt[1];
            rsp_result_d = 8'h00;
            rsp_err_d    = ERR_ILLEGAL;
          end else if ((sel_op == OP_DIV) && (sel_b == 4'h0)) begin
            state_d      = StResp;
            rsp_id_d     = gnt[1];
            rsp_result_d = 8'h00;
            rsp_err_d    = ERR_DIV0;
          end else begin
            state_d  = StIssue;
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
          end
        end
      end

      StIssue: begin
        cnt_d   = 8'h00;
        state_d = StWait;
      end

      StWait: begin
        cnt_d = cnt_inc[7:0];
        // cnt_q == 0 marks the first wait cycle, where a done left over from an
        // earlier operation may still be visible.
        if ((cnt_q != 8'h00) && bus.alu_done) begin
          state_d      = StResp;
          rsp_id_d     = id_q;
          rsp_result_d = bus.alu_result;
          rsp_err_d    = ERR_OK;
        end else if (cnt_inc >= TimeoutLim) begin
          state_d      = StResp;
          rsp_id_d     = id_q;
          rsp_result_d = 8'h00;
          rsp_err_d    = ERR_TIMEOUT;
        end
      end

      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 8'h00;
      id_q         <= 1'b0;
      alu_a_q      <= 4'h0;
      alu_b_q      <= 4'h0;
      alu_op_q     <= 4'h0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_err_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The ready pulse is decoded from the live request, so it is masked while reset is
  // held to keep every output quiet during reset.
  assign bus.req0_ready = take && gnt[0] && !rst;
  assign bus.req1_ready = take && gnt[1] && !rst;

  assign bus.alu_sel       = (state_q == StIssue);
  assign bus.alu_wr_enable = (state_q == StIssue);
  assign bus.alu_first_nr  = alu_a_q;
  assign bus.alu_second_nr = alu_b_q;
  assign bus.alu_operation = alu_op_q;

  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
module tb_alu_op_scheduler;
  import calc_pkg::*;

  localparam int Timeout = 32;

  logic clk;
  logic rst;

  alu_op_scheduler_if bus ();

  alu_op_scheduler #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_gnt = 1;   // reference arbiter: index granted last
  int alu_mode = 1;   // 0: done after alu_dly cycles, 1: never done, 2: done held from issue
  int alu_dly  = 0;
  int sel_count = 0;
  logic [3:0] iss_a, iss_b, iss_op;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0001: return 8'(a) + 8'(b);
      4'b0010: return 8'(a) * 8'(b);
      4'b0100: return (b == 4'h0) ? 8'h00 : 8'(a) / 8'(b);
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return {4'h0, bus.req0_ready, bus.req1_ready, bus.alu_sel, bus.alu_wr_enable,
            bus.alu_first_nr, bus.alu_second_nr, bus.alu_operation, bus.rsp_valid,
            bus.rsp_id, bus.rsp_result, bus.rsp_err};
  endfunction

  function automatic logic [3:0] rnd_nib();
    return 4'($urandom);
  endfunction

  function automatic logic [3:0] rnd_b();
    return ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
  endfunction

  function automatic logic [3:0] rnd_op();
    int r;
    r = $urandom_range(0, 7);
    if (r < 2) return OP_ADD;
    if (r < 4) return OP_MUL;
    if (r < 6) return OP_DIV;
    return 4'($urandom);
  endfunction

  // ALU model: counts launches, records the launched operands, answers per alu_mode.
  // alu_result carries junk except while done is asserted.
  initial begin : alu_model
    int cd;
    bit held;
    cd = 0;
    held = 0;
    bus.alu_done = 1'b0;
    bus.alu_result = 8'h00;
    forever begin
      @(negedge clk);
      bus.alu_done = 1'b0;
      bus.alu_result = 8'($urandom);
      if (rst) begin
        cd = 0;
        held = 0;
      end else if (bus.alu_sel) begin
        sel_count++;
        iss_a  = bus.alu_first_nr;
        iss_b  = bus.alu_second_nr;
        iss_op = bus.alu_operation;
        cd   = (alu_mode == 0) ? alu_dly : 0;
        held = (alu_mode == 2);
      end else if (held && bus.rsp_valid) begin
        held = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) bus.alu_done = 1'b1;
      end
      if (held) bus.alu_done = 1'b1;
      if (bus.alu_done) bus.alu_result = alu_fn(iss_a, iss_b, iss_op);
    end
  end

  // One complete command: present requests, check grant, response, latency and hold.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] op0,
                        input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] op1,
                        input int mode, input int dly, input int stall, input bit drop);
    int g, k, elat, t0, sel0;
    logic [3:0] ea, eb, eop;
    logic [1:0] eerr;
    logic [7:0] eres;
    bit launch, got, extra, unstable;

    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
    bus.rsp_ready = (stall == 0);
    alu_mode = mode;
    alu_dly  = dly;
    sel0 = sel_count;

    // reference: round-robin grant and outcome from the command's own fields
    if (v0 && v1) g = (last_gnt == 1) ? 0 : 1;
    else g = v1 ? 1 : 0;
    last_gnt = g;
    ea  = (g == 1) ? a1 : a0;
    eb  = (g == 1) ? b1 : b0;
    eop = (g == 1) ? op1 : op0;
    launch = 0;
    if (!(eop == OP_ADD || eop == OP_MUL || eop == OP_DIV)) begin
      eerr = ERR_ILLEGAL; eres = 8'h00; elat = 1;
    end else if (eop == OP_DIV && eb == 4'h0) begin
      eerr = ERR_DIV0; eres = 8'h00; elat = 1;
    end else begin
      launch = 1;
      if (mode == 2) k = 2;
      else if (mode == 0 && dly >= 2 && dly <= Timeout) k = dly;
      else k = -1;
      if (k < 0) begin
        eerr = ERR_TIMEOUT; eres = 8'h00; elat = Timeout + 2;
      end else begin
        eerr = ERR_OK; eres = alu_fn(ea, eb, eop); elat = k + 2;
      end
    end

    #1;
    check_eq("grant_ready0", bus.req0_ready, (g == 0));
    check_eq("grant_ready1", bus.req1_ready, (g == 1));
    t0 = cyc;
    got = 0;
    extra = 0;
    for (int i = 0; i < Timeout + 20; i++) begin
      @(negedge clk);
      if (drop) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      if (bus.req0_ready || bus.req1_ready) extra = 1;
      if (bus.rsp_valid) begin
        got = 1;
        break;
      end
    end
    check_eq("rsp_seen", got, 1);
    if (got) begin
      check_eq("rsp_latency", cyc - t0, elat);
      check_eq("rsp_id", bus.rsp_id, g);
      check_eq("rsp_result", bus.rsp_result, eres);
      check_eq("rsp_err", bus.rsp_err, eerr);
      check_eq("alu_sel_pulses", sel_count - sel0, launch ? 1 : 0);
      if (launch) check_eq("alu_bus", {iss_a, iss_b, iss_op}, {ea, eb, eop});
      check_eq("ready_single_pulse", extra, 0);
      unstable = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        #1;
        if (!bus.rsp_valid || bus.rsp_id !== 1'(g) || bus.rsp_result !== eres ||
            bus.rsp_err !== eerr || bus.req0_ready || bus.req1_ready) unstable = 1;
      end
      if (stall > 0) check_eq("rsp_stall_hold", unstable, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rsp_release", bus.rsp_valid, 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'($urandom);
  endtask

  // Abort a command in WAIT with reset; it must vanish without a response.
  task automatic reset_in_wait();
    bit seen;
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_a = 4'd7; bus.req1_b = 4'd2; bus.req1_op = OP_ADD;
    bus.rsp_ready = 1'b0;
    alu_mode = 1;
    repeat (4) @(negedge clk);
    bus.req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("outs_zero_rst_wait", all_outs(), 0);
    @(negedge clk);
    #1;
    check_eq("outs_zero_rst_hold", all_outs(), 0);
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    last_gnt = 1;
    seen = 0;
    for (int i = 0; i < Timeout + 8; i++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid || bus.alu_sel) seen = 1;
    end
    check_eq("no_rsp_after_abort", seen, 0);
  endtask

  initial begin
    logic [1:0] v;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_op = OP_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 4'd1; bus.req1_b = 4'd1; bus.req1_op = OP_ADD;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("outs_zero_reset", all_outs(), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("idle_after_reset", {bus.rsp_valid, bus.alu_sel}, 0);

    do_txn(1, 0, 4'd3, 4'd5, OP_ADD, 4'd0, 4'd0, 4'd0, 0, 3, 0, 1);
    do_txn(0, 1, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, OP_MUL, 0, 4, 0, 1);
    for (int n = 0; n < 4; n++) begin
      do_txn(1, 1, rnd_nib(), 4'd3, OP_ADD, rnd_nib(), 4'd2, OP_MUL,
             0, $urandom_range(2, 6), 0, 0);
    end
    do_txn(1, 0, 4'd9, 4'd0, OP_DIV, 4'd0, 4'd0, 4'd0, 0, 3, 0, 1);
    do_txn(1, 0, 4'd9, 4'd3, 4'b0011, 4'd0, 4'd0, 4'd0, 0, 3, 0, 1);
    do_txn(1, 0, 4'd6, 4'd7, OP_ADD, 4'd0, 4'd0, 4'd0, 1, 0, 0, 1);
    do_txn(0, 1, 4'd0, 4'd0, 4'd0, 4'd6, 4'd7, OP_MUL, 2, 0, 0, 1);
    do_txn(1, 0, 4'd12, 4'd3, OP_DIV, 4'd0, 4'd0, 4'd0, 0, Timeout, 0, 1);
    do_txn(1, 0, 4'd1, 4'd1, OP_ADD, 4'd0, 4'd0, 4'd0, 0, 1, 0, 1);

    reset_in_wait();
    do_txn(1, 1, 4'd5, 4'd6, OP_ADD, 4'd3, 4'd3, OP_MUL, 0, 2, 10, 0);

    for (int n = 0; n < 30; n++) begin
      v = 2'($urandom_range(1, 3));
      do_txn(v[0], v[1], rnd_nib(), rnd_b(), rnd_op(), rnd_nib(), rnd_b(), rnd_op(),
             $urandom_range(0, 2), $urandom_range(1, Timeout + 4), $urandom_range(0, 3),
             1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
